// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed N-digit 7-segment scan controller with frame-synchronous display update.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module digit_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int GAP    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            num,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic                  frame_done
);
    localparam int CW = $clog2(DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    typedef enum logic {S_GAP, S_SHOW} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic [DIGITS-1:0]   sdp_q, sdp_d, ddp_q, ddp_d;
    logic [3:0]          num_d, nib;
    logic                dp_n_d, fd_d, wrap;
    logic [DIGITS-1:0]   sel_d;

    // Load path: shadow takes every load; display copies shadow (or a coincident load) at the frame boundary
    always_comb begin
        shadow_d = load ? value_in : shadow_q;
        sdp_d    = load ? dp_in : sdp_q;
        disp_d   = frame_done ? shadow_d : disp_q;
        ddp_d    = frame_done ? sdp_d : ddp_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              run;
    // Leading zeros of the upcoming display value, scanning down from the top digit; digit 0 never blanks
    always_comb begin
        run   = 1'b1;
        blank = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            run      = run & (disp_d[4*k +: 4] == 4'h0) & ~ddp_d[k];
            blank[k] = run;
        end
    end
`endif

    // Slot counter, digit index, GAP/SHOW transition and the next values of the registered outputs
    always_comb begin
        wrap    = cnt_q == CNT_MAX;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? (idx_q == IDX_MAX ? '0 : idx_q + 1'b1) : idx_q;
        state_d = wrap ? S_GAP : (cnt_d == GAP_C ? S_SHOW : state_q);
        fd_d    = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
        nib     = disp_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        num_d   = blank[idx_d] ? 4'hF : nib;
`else
        num_d   = nib;
`endif
        dp_n_d  = state_d == S_SHOW ? ~ddp_d[idx_d] : 1'b1;
        sel_d   = state_d == S_SHOW ? ~(DIGITS'(1) << idx_d) : '1;
    end

    // State, storage and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_GAP;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '1;
            sdp_q       <= '0;
            disp_q      <= '1;
            ddp_q       <= '0;
            num         <= 4'hF;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            disp_q      <= disp_d;
            ddp_q       <= ddp_d;
            num         <= num_d;
            dp_n        <= dp_n_d;
            digit_sel_n <= sel_d;
            frame_done  <= fd_d;
        end
    end
endmodule
